// File: rtl/fir_coeff_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_ctrl_pkg
//
// Shared constants and types for the FIR coefficient/sequencing controller.
//
// Contents:
//   NUM_COEFF      number of unique half-filter coefficients (16-tap symmetric)
//   COEFF_W        signed coefficient width
//   ADDR_W         minimum width needed to index NUM_COEFF coefficients
//   FLAT_W         width of the flattened coefficient bus
//   coeff_t        signed coefficient type
//   coeff_bank_t   one full coefficient bank (unpacked, index 0..NUM_COEFF-1)
//   commit_state_e state of the shadow-to-active commit handshake
//   DEFAULT_COEFF  coefficient set loaded into both banks on reset
//   pack_bank()    flattens a bank, index 0 in the least significant slot
// -----------------------------------------------------------------------------
package fir_ctrl_pkg;

   localparam int NUM_COEFF = 8;
   localparam int COEFF_W   = 16;
   localparam int ADDR_W    = $clog2(NUM_COEFF);
   localparam int FLAT_W    = NUM_COEFF * COEFF_W;

   typedef logic signed [COEFF_W-1:0] coeff_t;
   typedef coeff_t coeff_bank_t [NUM_COEFF];

   // IDLE: shadow may be written, no swap outstanding.
   // PENDING: swap requested, waiting for the next sample boundary.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } commit_state_e;

   // Power-on low-pass response, centre tap last (index 7).
   localparam coeff_bank_t DEFAULT_COEFF = '{
      coeff_t'(2552),  coeff_t'(4557),  coeff_t'(5051),  coeff_t'(8006),
      coeff_t'(9265),  coeff_t'(11427), coeff_t'(12396), coeff_t'(13200)
   };

   function automatic logic [FLAT_W-1:0] pack_bank(input coeff_bank_t bank);
      logic [FLAT_W-1:0] flat;
      flat = '0;
      for (int i = 0; i < NUM_COEFF; i++) begin
         flat[i*COEFF_W +: COEFF_W] = bank[i];
      end
      return flat;
   endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// -----------------------------------------------------------------------------
// fir_coeff_ctrl_if
//
// Bundles the host-side coefficient write/commit handshake and the
// filter-side outputs of the FIR coefficient controller.
//
// Parameter:
//   WR_ADDR_W   width of wr_addr (defaults to the minimum index width; a wider
//               address lets a driver present out-of-range indices)
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   wr_valid        in   coefficient write request
//   wr_ready        out  write accepted when wr_valid & wr_ready
//   wr_addr         in   coefficient index
//   wr_data         in   signed coefficient value
//   wr_err          out  one-cycle pulse: accepted write was out of range
//   commit          in   request shadow-to-active swap
//   commit_pending  out  swap requested, not yet performed
//   commit_done     out  one-cycle pulse after the swap
//   sample_en       out  filter advance strobe (FIR en)
//   coeff_flat      out  active bank, index 0 at the least significant slot
//
// Modports: master = host / update logic, slave = fir_coeff_ctrl.
// -----------------------------------------------------------------------------
interface fir_coeff_ctrl_if #(
   parameter int WR_ADDR_W = fir_ctrl_pkg::ADDR_W
) ();
   import fir_ctrl_pkg::*;

   logic                 wr_valid;
   logic                 wr_ready;
   logic [WR_ADDR_W-1:0] wr_addr;
   coeff_t               wr_data;
   logic                 wr_err;
   logic                 commit;
   logic                 commit_pending;
   logic                 commit_done;
   logic                 sample_en;
   logic [FLAT_W-1:0]    coeff_flat;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      output commit,
      input  wr_ready,
      input  wr_err,
      input  commit_pending,
      input  commit_done,
      input  sample_en,
      input  coeff_flat
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      input  commit,
      output wr_ready,
      output wr_err,
      output commit_pending,
      output commit_done,
      output sample_en,
      output coeff_flat
   );

endinterface

// File: rtl/fir_coeff_ctrl_rate.sv
// -----------------------------------------------------------------------------
// rate_enable_gen
//
// Free-running modulo-RATE_DIV counter that produces the sample-rate strobe
// advancing the FIR delay line.
//
// Parameter:
//   RATE_DIV     clock cycles per sample, legal range 1..256
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   sample_en_o  out  high in the last cycle of each sample period
//
// The counter restarts at 0 on reset, so the first strobe comes in the
// RATE_DIV-th cycle after reset is released.
// -----------------------------------------------------------------------------
module rate_enable_gen #(
   parameter int RATE_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic sample_en_o
);

   // RATE_DIV = 1 still needs a one-bit counter; it simply stays at 0.
   localparam int               CNT_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Masked by rst so that no strobe leaks out while the counter is held.
   assign sample_en_o = (cnt_q == CNT_LAST) & ~rst;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// fir_coeff_ctrl
//
// Sequencing and configuration controller for the 16-tap symmetric FIR.
// Generates the sample-rate strobe and owns the NUM_COEFF half-filter
// coefficients as a double-buffered bank: writes land in the shadow bank,
// a commit swaps shadow into active on a sample boundary so the filter never
// sees a mixed coefficient set.
//
// Parameters:
//   RATE_DIV    clock cycles per sample (1..256)
//   WR_ADDR_W   width of bus.wr_addr, must match the connected interface
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset; restores defaults in both banks
//   bus   fir_coeff_ctrl_if.slave  write/commit handshake and filter outputs
// -----------------------------------------------------------------------------
module fir_coeff_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int RATE_DIV  = 4,
   parameter int WR_ADDR_W = ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   fir_coeff_ctrl_if.slave        bus
);

   commit_state_e state_q;
   commit_state_e state_d;
   coeff_bank_t   shadow_q;
   coeff_bank_t   shadow_d;
   coeff_bank_t   active_q;
   coeff_bank_t   active_d;
   logic          done_q;
   logic          done_d;
   logic          err_q;
   logic          err_d;

   logic              sample_en;
   logic              wr_ready;
   logic              wr_fire;
   logic              addr_ok;
   logic [ADDR_W-1:0] wr_idx;

   rate_enable_gen #(
      .RATE_DIV (RATE_DIV)
   ) u_rate (
      .clk         (clk),
      .rst         (rst),
      .sample_en_o (sample_en)
   );

   // Writes are refused while a swap is outstanding, which keeps the shadow
   // bank frozen between the commit request and the swap.
   assign wr_ready = (state_q == ST_IDLE);
   assign wr_fire  = bus.wr_valid & wr_ready;
   assign wr_idx   = bus.wr_addr[ADDR_W-1:0];

   // The range check only exists when the address bus can express an index
   // beyond the bank; otherwise every address is valid by construction.
   generate
      if ((1 << WR_ADDR_W) > NUM_COEFF) begin : g_range_chk
         assign addr_ok = (int'(bus.wr_addr) < NUM_COEFF);
      end else begin : g_range_all
         assign addr_ok = 1'b1;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.commit) begin
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // Swap on the same edge that advances the delay line, so the new
            // set applies from the very next sample. A commit seen here is
            // deliberately ignored.
            if (sample_en) begin
               state_d  = ST_IDLE;
               active_d = shadow_q;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A write accepted together with a commit lands in the shadow at the
      // same edge the request is registered, so it is part of the swap.
      if (wr_fire) begin
         if (addr_ok) begin
            shadow_d[wr_idx] = bus.wr_data;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         shadow_q <= DEFAULT_COEFF;
         active_q <= DEFAULT_COEFF;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         err_q    <= err_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign bus.wr_ready       = wr_ready;
   assign bus.wr_err         = err_q;
   assign bus.commit_pending = (state_q == ST_PENDING);
   assign bus.commit_done    = done_q;
   assign bus.sample_en      = sample_en;
   assign bus.coeff_flat     = pack_bank(active_q);

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_ctrl
//
// Directed test-plan scenarios followed by a randomized run. A cycle-level
// reference model (sample index since reset, shadow/active arrays, pending
// flag) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fir_coeff_ctrl;
   import fir_ctrl_pkg::*;

   localparam int RD = 4;
   localparam int AW = 4;

   localparam logic signed [15:0] DEF [8] = '{
      16'sd2552, 16'sd4557, 16'sd5051, 16'sd8006,
      16'sd9265, 16'sd11427, 16'sd12396, 16'sd13200
   };

   logic clk;
   logic rst;

   fir_coeff_ctrl_if #(.WR_ADDR_W(AW)) bus ();

   fir_coeff_ctrl #(
      .RATE_DIV  (RD),
      .WR_ADDR_W (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   int n_done_seen;
   int n_werr_seen;
   bit checking;

   // Reference model state
   int                  cyc;      // 1-based cycle index since reset release
   logic signed [15:0]  sh_m [8];
   logic signed [15:0]  ac_m [8];
   bit                  pend_m;
   bit                  done_m;
   bit                  err_m;

   task automatic check_val(input string tag, input logic [FLAT_W-1:0] got,
                            input logic [FLAT_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_update();
      bit se;
      bit fire;
      if (rst) begin
         cyc = 1;
         for (int i = 0; i < 8; i++) begin
            sh_m[i] = DEF[i];
            ac_m[i] = DEF[i];
         end
         pend_m = 0;
         done_m = 0;
         err_m  = 0;
      end else begin
         se     = (cyc % RD == 0);
         fire   = bus.wr_valid && !pend_m;
         err_m  = fire && (bus.wr_addr >= 8);
         done_m = pend_m && se;
         if (pend_m && se) begin
            ac_m   = sh_m;
            pend_m = 0;
         end else if (bus.commit && !pend_m) begin
            pend_m = 1;
         end
         if (fire && bus.wr_addr < 8) sh_m[bus.wr_addr[2:0]] = bus.wr_data;
         cyc++;
      end
   endtask

   // One clock cycle: inputs already driven; compare at negedge, then advance.
   task automatic step();
      logic [FLAT_W-1:0] exp_flat;
      logic              exp_se;
      @(negedge clk);
      if (checking) begin
         exp_se = !rst && (cyc % RD == 0);
         for (int i = 0; i < 8; i++) exp_flat[i*16 +: 16] = ac_m[i];
         check_val("sample_en",      bus.sample_en,      exp_se);
         check_val("wr_ready",       bus.wr_ready,       !pend_m);
         check_val("commit_pending", bus.commit_pending, pend_m);
         check_val("commit_done",    bus.commit_done,    done_m);
         check_val("wr_err",         bus.wr_err,         err_m);
         check_val("coeff_flat",     bus.coeff_flat,     exp_flat);
      end
      if (bus.commit_done === 1'b1) n_done_seen++;
      if (bus.wr_err === 1'b1)      n_werr_seen++;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic signed [15:0] d, input logic c);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      bus.commit   = c;
      step();
      bus.wr_valid = 1'b0;
      bus.commit   = 1'b0;
   endtask

   // Advance until the current cycle sits at the requested phase (cyc % RD).
   task automatic align(input int phase);
      for (int g = 0; g < RD && (cyc % RD) != phase; g++) step();
   endtask

   initial begin
      int done0;
      int err0;
      n_vec = 0; n_err = 0; n_done_seen = 0; n_werr_seen = 0;
      checking = 0;
      cyc = 0;
      rst = 1'b1;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.commit   = 1'b0;
      #1;

      // Reset and release: strobes at cycles 4, 8, 12, defaults visible
      step();
      checking = 1;
      step();
      rst = 1'b0;
      idle(12);

      // Shadow write without commit never reaches the active bank
      wr(4'd3, -16'sd1000, 1'b0);
      idle(20);

      // Write + commit in the same cycle at counter value 1
      align(2);
      done0 = n_done_seen;
      wr(4'd0, 16'sd100, 1'b1);
      idle(8);
      check_val("commit_once_a", 32'(n_done_seen - done0), 32'd1);

      // Write held while pending, second commit ignored
      done0 = n_done_seen;
      bus.commit = 1'b1;
      step();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 4'd1;
      bus.wr_data  = 16'sd777;
      step();
      bus.commit = 1'b0;
      idle(6);
      bus.wr_valid = 1'b0;
      idle(6);
      check_val("commit_once_b", 32'(n_done_seen - done0), 32'd1);

      // In-range then out-of-range address
      err0 = n_werr_seen;
      wr(4'd7, 16'sd5, 1'b0);
      wr(4'd8, 16'sd9, 1'b0);
      idle(3);
      check_val("wr_err_once", 32'(n_werr_seen - err0), 32'd1);
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      idle(6);

      // Reset while a commit is pending
      wr(4'd2, -16'sd42, 1'b0);
      align(2);
      done0 = n_done_seen;
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      check_val("pending_pre_rst", bus.commit_pending, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(12);
      check_val("no_done_after_rst", 32'(n_done_seen - done0), 32'd0);
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      idle(6);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         bus.wr_valid = ($urandom_range(0, 9) < 4);
         bus.wr_addr  = AW'($urandom_range(0, 9));
         bus.wr_data  = 16'($urandom);
         bus.commit   = ($urandom_range(0, 9) == 0);
         step();
      end
      rst = 1'b0;
      bus.wr_valid = 1'b0;
      bus.commit   = 1'b0;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
